// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and widths for the writeback stage
package cpu_pkg;

  localparam int CPU_DATA_WIDTH     = 32;
  localparam int CPU_REG_COUNT      = 32;
  localparam int CPU_REG_ADDR_WIDTH = $clog2(CPU_REG_COUNT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1
  } wb_state_e;

endpackage

// File: rtl/cpu_regfile_2r1w.sv
// rtl/cpu_regfile_2r1w.sv - architectural register file, two read ports with write-through bypass
module cpu_regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = CPU_DATA_WIDTH,
  parameter int REG_COUNT      = CPU_REG_COUNT,
  parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0]     rdata_a_o,
  output logic [DATA_WIDTH-1:0]     rdata_b_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is hardwired to zero, so it never bypasses even if a write targets it
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != '0) rdata_a_o = (we_i && waddr_i == raddr_a_i) ? wdata_i : regs_q[raddr_a_i];
    if (raddr_b_i != '0) rdata_b_o = (we_i && waddr_i == raddr_b_i) ? wdata_i : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/cpu_writeback_regfile.sv
// rtl/cpu_writeback_regfile.sv - writeback stage: ALU/load commit into the register file
module cpu_writeback_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = CPU_DATA_WIDTH,
  parameter int REG_COUNT      = CPU_REG_COUNT,
  parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wb_valid_i,
  output logic                      wb_ready_o,
  input  logic                      wb_reg_write_i,
  input  logic                      wb_mem_to_reg_i,
  input  logic [DATA_WIDTH-1:0]     wb_alu_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_reg_dest_i,
  input  logic                      mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b_i,
  output logic [DATA_WIDTH-1:0]     rd_data_a_o,
  output logic [DATA_WIDTH-1:0]     rd_data_b_o,
  output logic [REG_ADDR_WIDTH-1:0] fw_rd_wb_o,
  output logic                      fw_reg_write_wb_o,
  output logic [DATA_WIDTH-1:0]     fw_data_wb_o,
  output logic [31:0]               retire_count_o,
  output logic                      err_timeout_o,
  output logic                      err_unexpected_rsp_o
);

  localparam bit          TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(MEM_TIMEOUT) - 32'd1;

  wb_state_e               state_q;
  logic [REG_ADDR_WIDTH-1:0] pdest_q;
  logic [31:0]             timer_q;
  logic [31:0]             retire_q;
  logic [31:0]             retire_d;
  logic                    err_timeout_q;
  logic                    err_unexp_q;

  logic accept, alu_we, mem_we, we, timeout_hit;

  assign wb_ready_o  = (state_q == IDLE);
  assign accept      = wb_valid_i && wb_ready_o;
  assign alu_we      = accept && wb_reg_write_i && !wb_mem_to_reg_i && (wb_reg_dest_i != '0);
  assign mem_we      = (state_q == WAIT_MEM) && mem_rsp_valid_i && (pdest_q != '0);
  assign we          = alu_we || mem_we;
  // timer_q counts completed wait cycles, so the current one is the last allowed
  assign timeout_hit = TIMEOUT_EN && (timer_q >= TIMEOUT_LAST);
  assign retire_d    = retire_q + 32'd1;

  assign fw_reg_write_wb_o = we;
  assign fw_rd_wb_o        = alu_we ? wb_reg_dest_i : (mem_we ? pdest_q : '0);
  assign fw_data_wb_o      = alu_we ? wb_alu_data_i : (mem_we ? mem_rsp_data_i : '0);

  assign retire_count_o       = retire_q;
  assign err_timeout_o        = err_timeout_q;
  assign err_unexpected_rsp_o = err_unexp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pdest_q       <= '0;
      timer_q       <= '0;
      retire_q      <= '0;
      err_timeout_q <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      if (we) retire_q <= retire_d;
      case (state_q)
        IDLE: begin
          if (mem_rsp_valid_i) err_unexp_q <= 1'b1;
          if (accept && wb_reg_write_i && wb_mem_to_reg_i) begin
            pdest_q <= wb_reg_dest_i;
            timer_q <= '0;
            state_q <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (mem_rsp_valid_i) begin
            state_q <= IDLE;
          end else begin
            if (timer_q != '1) timer_q <= timer_q + 32'd1;
            if (timeout_hit) begin
              err_timeout_q <= 1'b1;
              state_q       <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cpu_regfile_2r1w #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_COUNT     (REG_COUNT),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (we),
    .waddr_i  (fw_rd_wb_o),
    .wdata_i  (fw_data_wb_o),
    .raddr_a_i(rd_addr_a_i),
    .raddr_b_i(rd_addr_b_i),
    .rdata_a_o(rd_data_a_o),
    .rdata_b_o(rd_data_b_o)
  );

endmodule

// File: tb/tb_cpu_writeback_regfile.sv
// tb/tb_cpu_writeback_regfile.sv - directed vectors plus a cycle model of the writeback stage
module tb_cpu_writeback_regfile;

  localparam int TMO = 4;

  logic        clk, rst_n;
  logic        wb_valid, wb_ready, wb_reg_write, wb_mem_to_reg;
  logic [31:0] wb_alu_data;
  logic [4:0]  wb_reg_dest;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [4:0]  fw_rd_wb;
  logic        fw_reg_write_wb;
  logic [31:0] fw_data_wb;
  logic [31:0] retire_count;
  logic        err_timeout, err_unexpected_rsp;

  int checks = 0;
  int errors = 0;

  cpu_writeback_regfile #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .wb_valid_i          (wb_valid),
    .wb_ready_o          (wb_ready),
    .wb_reg_write_i      (wb_reg_write),
    .wb_mem_to_reg_i     (wb_mem_to_reg),
    .wb_alu_data_i       (wb_alu_data),
    .wb_reg_dest_i       (wb_reg_dest),
    .mem_rsp_valid_i     (mem_rsp_valid),
    .mem_rsp_data_i      (mem_rsp_data),
    .rd_addr_a_i         (rd_addr_a),
    .rd_addr_b_i         (rd_addr_b),
    .rd_data_a_o         (rd_data_a),
    .rd_data_b_o         (rd_data_b),
    .fw_rd_wb_o          (fw_rd_wb),
    .fw_reg_write_wb_o   (fw_reg_write_wb),
    .fw_data_wb_o        (fw_data_wb),
    .retire_count_o      (retire_count),
    .err_timeout_o       (err_timeout),
    .err_unexpected_rsp_o(err_unexpected_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural state as plain variables, advanced once per cycle
  logic [31:0] m_regs [32];
  bit          m_waiting;
  int          m_pdest;
  int          m_waited;
  logic [31:0] m_retire;
  bit          m_err_to, m_err_un;

  always @(negedge clk) begin
    bit          e_we;
    int          e_addr;
    logic [31:0] e_data, e_a, e_b;
    bit          acc;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_waiting = 0; m_pdest = 0; m_waited = 0;
      m_retire = '0; m_err_to = 0; m_err_un = 0;
    end
    acc    = wb_valid && !m_waiting && rst_n;
    e_we   = 0; e_addr = 0; e_data = '0;
    if (acc && wb_reg_write && !wb_mem_to_reg && wb_reg_dest != 0) begin
      e_we = 1; e_addr = int'(wb_reg_dest); e_data = wb_alu_data;
    end else if (m_waiting && mem_rsp_valid && m_pdest != 0) begin
      e_we = 1; e_addr = m_pdest; e_data = mem_rsp_data;
    end
    e_a = (rd_addr_a == 0) ? 32'd0 : (e_we && e_addr == int'(rd_addr_a)) ? e_data : m_regs[rd_addr_a];
    e_b = (rd_addr_b == 0) ? 32'd0 : (e_we && e_addr == int'(rd_addr_b)) ? e_data : m_regs[rd_addr_b];

    chk("m_ready",  {31'd0, wb_ready}, {31'd0, !m_waiting});
    chk("m_fw_we",  {31'd0, fw_reg_write_wb}, {31'd0, e_we});
    chk("m_fw_rd",  {27'd0, fw_rd_wb}, 32'(e_addr));
    chk("m_fw_data", fw_data_wb, e_data);
    chk("m_rd_a",   rd_data_a, e_a);
    chk("m_rd_b",   rd_data_b, e_b);
    chk("m_retire", retire_count, m_retire);
    chk("m_err_to", {31'd0, err_timeout}, {31'd0, m_err_to});
    chk("m_err_un", {31'd0, err_unexpected_rsp}, {31'd0, m_err_un});

    if (rst_n) begin
      if (e_we) begin
        m_regs[e_addr] = e_data;
        m_retire = m_retire + 32'd1;
      end
      if (m_waiting) begin
        if (mem_rsp_valid) m_waiting = 0;
        else begin
          m_waited++;
          if (TMO != 0 && m_waited == TMO) begin
            m_err_to = 1; m_waiting = 0;
          end
        end
      end else begin
        if (mem_rsp_valid) m_err_un = 1;
        if (acc && wb_reg_write && wb_mem_to_reg) begin
          m_waiting = 1; m_pdest = int'(wb_reg_dest); m_waited = 0;
        end
      end
    end
  end

  task automatic pkt(input logic v, input logic rw, input logic m2r, input logic [31:0] d, input logic [4:0] dst);
    wb_valid = v; wb_reg_write = rw; wb_mem_to_reg = m2r; wb_alu_data = d; wb_reg_dest = dst;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pkt(0, 0, 0, '0, '0);
    mem_rsp_valid = 0; mem_rsp_data = '0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, wb_ready}, 32'd1);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_rd_a", rd_data_a, 32'd0);
    rst_n = 1'b1;
    tick;

    // ALU write r5
    pkt(1, 1, 0, 32'hDEADBEEF, 5'd5);
    @(negedge clk);
    chk("alu_fw_we", {31'd0, fw_reg_write_wb}, 32'd1);
    chk("alu_fw_rd", {27'd0, fw_rd_wb}, 32'd5);
    chk("alu_bypass", rd_data_a, 32'hDEADBEEF);
    tick; pkt(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("alu_stored", rd_data_a, 32'hDEADBEEF);
    chk("alu_retire", retire_count, 32'd1);

    // Load r7, response three cycles after accept
    rd_addr_a = 5'd7;
    tick; pkt(1, 1, 1, 32'h0, 5'd7);
    tick; pkt(0, 0, 0, '0, '0);
    @(negedge clk); chk("ld_ready_c1", {31'd0, wb_ready}, 32'd0);
    tick;
    @(negedge clk); chk("ld_ready_c2", {31'd0, wb_ready}, 32'd0);
    tick; mem_rsp_valid = 1; mem_rsp_data = 32'h12345678;
    @(negedge clk);
    chk("ld_ready_c3", {31'd0, wb_ready}, 32'd0);
    chk("ld_fw_rd", {27'd0, fw_rd_wb}, 32'd7);
    chk("ld_bypass", rd_data_a, 32'h12345678);
    tick; mem_rsp_valid = 0;
    @(negedge clk);
    chk("ld_ready_back", {31'd0, wb_ready}, 32'd1);
    chk("ld_stored", rd_data_a, 32'h12345678);
    chk("ld_retire", retire_count, 32'd2);

    // ALU write to r0 is suppressed
    rd_addr_a = 5'd0;
    tick; pkt(1, 1, 0, 32'hFFFFFFFF, 5'd0);
    @(negedge clk);
    chk("r0_fw_we", {31'd0, fw_reg_write_wb}, 32'd0);
    chk("r0_rd", rd_data_a, 32'd0);
    tick; pkt(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("r0_retire", retire_count, 32'd2);

    // reg_write=0 with mem_to_reg=1 does nothing
    tick; pkt(1, 0, 1, 32'h55, 5'd4);
    tick; pkt(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("nowr_ready", {31'd0, wb_ready}, 32'd1);

    // Load r3 that times out after TMO wait cycles
    rd_addr_b = 5'd3;
    tick; pkt(1, 1, 1, 32'h0, 5'd3);
    tick; pkt(0, 0, 0, '0, '0);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      chk("to_wait_ready", {31'd0, wb_ready}, 32'd0);
      chk("to_wait_err", {31'd0, err_timeout}, 32'd0);
      tick;
    end
    @(negedge clk);
    chk("to_ready", {31'd0, wb_ready}, 32'd1);
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_r3", rd_data_b, 32'd0);
    chk("to_unexp0", {31'd0, err_unexpected_rsp}, 32'd0);
    tick; mem_rsp_valid = 1; mem_rsp_data = 32'hAAAA5555;
    tick; mem_rsp_valid = 0;
    @(negedge clk);
    chk("late_unexp", {31'd0, err_unexpected_rsp}, 32'd1);
    chk("late_r3", rd_data_b, 32'd0);

    // Reset asserted while waiting for a load
    rd_addr_a = 5'd7; rd_addr_b = 5'd5;
    tick; pkt(1, 1, 1, 32'h0, 5'd9);
    tick; pkt(0, 0, 0, '0, '0);
    #1 chk("pre_rst_ready", {31'd0, wb_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, wb_ready}, 32'd1);
    chk("arst_r7", rd_data_a, 32'd0);
    chk("arst_r5", rd_data_b, 32'd0);
    chk("arst_err_to", {31'd0, err_timeout}, 32'd0);
    chk("arst_err_un", {31'd0, err_unexpected_rsp}, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    tick;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, wb_ready}, 32'd1);
    tick; mem_rsp_valid = 1; mem_rsp_data = 32'h99;
    tick; mem_rsp_valid = 0;
    @(negedge clk);
    chk("post_rst_unexp", {31'd0, err_unexpected_rsp}, 32'd1);

    // Back-to-back ALU writes r1, r2, r1
    tick; pkt(1, 1, 0, 32'd1, 5'd1);
    tick; pkt(1, 1, 0, 32'd2, 5'd2);
    tick; pkt(1, 1, 0, 32'd3, 5'd1);
    tick; pkt(0, 0, 0, '0, '0); rd_addr_a = 5'd1; rd_addr_b = 5'd2;
    @(negedge clk);
    chk("b2b_r1", rd_data_a, 32'd3);
    chk("b2b_r2", rd_data_b, 32'd2);
    chk("b2b_retire", retire_count, 32'd3);

    tick; tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
